reassemble_pkt: RTL

//  RX-side counterpart of the TX fragmenter. Collects AURORA_WIDTH beats from the Aurora

---
 rtl/reassemble_pkt_if.sv | 34 +++
 rtl/reassemble_pkt.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/reassemble_pkt_if.sv
`default_nettype none
// ============================================================================
//  Module      : reassemble_pkt_if
//  Description : Aurora user-RX beat stream plus reassembled-packet
//                valid/ready channel for reassemble_pkt.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reassemble_pkt_if #(
  parameter int AURORA_WIDTH = 256,
  parameter int PKT_WIDTH    = 1041,
  parameter int DFX_WIDTH    = 2
);
  logic                    rx_valid;
  logic [AURORA_WIDTH-1:0] rx_data;
  logic                    rx_last;
  logic                    pkt_valid;
  logic                    pkt_ready;
  logic [PKT_WIDTH-1:0]    pkt_data;
  logic [DFX_WIDTH-1:0]    pkt_src_dfx;
  logic                    pkt_is_ack;

  // Source of beats and sink of packets
  modport master (
    output rx_valid, rx_data, rx_last, pkt_ready,
    input  pkt_valid, pkt_data, pkt_src_dfx, pkt_is_ack
  );

  // The reassembler itself
  modport slave (
    input  rx_valid, rx_data, rx_last, pkt_ready,
    output pkt_valid, pkt_data, pkt_src_dfx, pkt_is_ack
  );
endinterface
`default_nettype wire

// File: rtl/reassemble_pkt.sv
`default_nettype none
// ============================================================================
//  Module      : reassemble_pkt
//  Description : Rebuilds one PKT_WIDTH packet from NUM_BEATS Aurora beats,
//                drops malformed or overflowing frames and counts the drops.
//  Revision    : 1.0 - initial release
// ============================================================================
module reassemble_pkt #(
  parameter int DATA_WIDTH     = 1024,
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_DFX_WIDTH = DATA_WIDTH + ADDR_WIDTH,
  parameter int ACK_WIDTH      = 1,
  parameter int SEQ_NUM_WIDTH  = 1,
  parameter int DFX_WIDTH      = 2,
  parameter int PKT_WIDTH      = DATA_DFX_WIDTH + ACK_WIDTH + 2*SEQ_NUM_WIDTH + 2*DFX_WIDTH,
  parameter int AURORA_WIDTH   = 256
) (
  input  logic              clk,
  input  logic              rst,
  reassemble_pkt_if.slave   bus,
  output logic              err_len,
  output logic              err_ovf,
  output logic [15:0]       drop_cnt
);

  localparam int NUM_BEATS = (PKT_WIDTH + AURORA_WIDTH - 1) / AURORA_WIDTH;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BEATS - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ASSEMBLE = 2'd1;
  localparam logic [1:0] DISCARD  = 2'd2;

  logic [1:0]           r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_beat_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]     w_idx;
  logic                 w_wr, w_complete, w_len_err, w_ovf, w_load, w_accept;
  logic [PKT_WIDTH-1:0] w_asm_nxt;
  logic [PKT_WIDTH-1:0] r_pkt_data;
  logic                 r_pkt_valid;
  logic                 r_err_len, r_err_ovf;
  logic [15:0]          r_drop_cnt;

  // Frame FSM: decides which slice a beat lands in and whether the frame ends well or badly
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_beat_cnt;
    w_idx       = r_beat_cnt;
    w_wr        = 1'b0;
    w_complete  = 1'b0;
    w_len_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.rx_valid) begin
          w_wr      = 1'b1;
          w_idx     = '0;
          w_cnt_nxt = CNT_W'(1);
          if (bus.rx_last) begin
            // single-beat frame is only legal when one beat holds the whole packet
            if (NUM_BEATS == 1) w_complete = 1'b1;
            else                w_len_err  = 1'b1;
            w_cnt_nxt = '0;
          end else if (NUM_BEATS == 1) begin
            w_len_err   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = DISCARD;
          end else begin
            w_state_nxt = ASSEMBLE;
          end
        end
      end
      ASSEMBLE: begin
        if (bus.rx_valid) begin
          w_wr = 1'b1;
          if (bus.rx_last) begin
            if (r_beat_cnt == LAST_IDX) w_complete = 1'b1;
            else                        w_len_err  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else if (r_beat_cnt == LAST_IDX) begin
            // too long: flag once now and swallow the rest of the frame silently
            w_len_err   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = DISCARD;
          end else begin
            w_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      DISCARD: begin
        if (bus.rx_valid && bus.rx_last) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state and beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_cnt_nxt;
    end
  end

  // One storage slice per beat; the last slice keeps only the bits below PKT_WIDTH.
  // w_asm_nxt already includes the beat being written, so completion loads in the same cycle.
  for (genvar k = 0; k < NUM_BEATS; k++) begin : g_beat
    localparam int LO = k * AURORA_WIDTH;
    localparam int W  = (PKT_WIDTH - LO < AURORA_WIDTH) ? (PKT_WIDTH - LO) : AURORA_WIDTH;
    logic [W-1:0] r_slice;
    logic         w_sel;
    assign w_sel             = w_wr && (w_idx == CNT_W'(k));
    assign w_asm_nxt[LO +: W] = w_sel ? bus.rx_data[W-1:0] : r_slice;

    // capture this beat's slice of the packet
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_slice <= '0;
      else if (w_sel) r_slice <= bus.rx_data[W-1:0];
    end
  end

  assign w_accept = r_pkt_valid & bus.pkt_ready;
  assign w_load   = w_complete & (~r_pkt_valid | w_accept);
  assign w_ovf    = w_complete & ~w_load;

  // One-deep output buffer: a held packet is never overwritten
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_valid <= 1'b0;
      r_pkt_data  <= '0;
    end else if (w_load) begin
      r_pkt_valid <= 1'b1;
      r_pkt_data  <= w_asm_nxt;
    end else if (w_accept) begin
      r_pkt_valid <= 1'b0;
    end
  end

  // Error pulses and saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_len  <= 1'b0;
      r_err_ovf  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_err_len <= w_len_err;
      r_err_ovf <= w_ovf;
      if ((w_len_err | w_ovf) && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.pkt_valid   = r_pkt_valid;
  assign bus.pkt_data    = r_pkt_data;
  assign bus.pkt_src_dfx = r_pkt_data[PKT_WIDTH-DFX_WIDTH-1 -: DFX_WIDTH];
  assign bus.pkt_is_ack  = r_pkt_data[DATA_DFX_WIDTH];
  assign err_len         = r_err_len;
  assign err_ovf         = r_err_ovf;
  assign drop_cnt        = r_drop_cnt;

endmodule
`default_nettype wire
